// File: rtl/if_loop_1_pkg.sv
// Shared types, widths and the round-robin grant helper for the if_loop_1 call scheduler.
package if_loop_1_pkg;

    localparam int unsigned A_W    = 64;
    localparam int unsigned N_W    = 32;
    localparam int unsigned RET_W  = 32;
    localparam int unsigned RR_MAX = 16;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [N_W-1:0] n;
    } call_req_t;

    // First valid requester at or after ptr, wrapping modulo nreq; one-hot result.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                  input logic [3:0]        ptr,
                                                  input int unsigned       nreq);
        logic [RR_MAX-1:0] grant;
        logic              found;
        int unsigned       idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = (32'(ptr) + i) % nreq;
            if (i < nreq && !found && valid[idx[3:0]]) begin
                grant[idx[3:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sched_id_fifo.sv
// Synchronous FIFO holding requester ids of calls in flight; push and pop may coincide.
module sched_id_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/if_loop_1_call_sched.sv
// Round-robin call scheduler sharing one if_loop_1 component among NREQ requesters,
// tagging in-order results with the originating requester id.
module if_loop_1_call_sched
    import if_loop_1_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDW   = $clog2(NREQ),
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*64-1:0] req_a,
    input  logic [NREQ*32-1:0] req_n,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_data,
    output logic               comp_start,
    input  logic               comp_busy,
    output logic [63:0]        comp_a,
    output logic [31:0]        comp_n,
    input  logic               comp_done,
    output logic               comp_stall,
    input  logic [31:0]        comp_returndata,
    output logic [CW-1:0]      outstanding,
    output logic               err_unexpected_done,
    output logic [31:0]        calls_issued,
    output logic [31:0]        calls_done
);

    typedef enum logic {IDLE, CALL} state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr, pend_id, win_id;
    logic [RR_MAX-1:0] grant_w;
    logic [NREQ-1:0]   grant;
    call_req_t         win_req;
    logic              any_valid, accept, latch, pop;
    logic              fifo_empty, fifo_full;
    logic [IDW-1:0]    fifo_head;

    always_comb begin
        grant_w = rr_pick(RR_MAX'(req_valid), 4'(rr_ptr), NREQ);
        grant   = grant_w[NREQ-1:0];
        win_id  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) win_id = IDW'(i);
        end
        win_req.a = req_a[int'(win_id)*A_W +: A_W];
        win_req.n = req_n[int'(win_id)*N_W +: N_W];
    end

    assign any_valid  = |req_valid;
    // Full is the registered count, so an accepted call can never overflow the id FIFO.
    assign comp_start = (state == CALL) && !fifo_full;
    assign accept     = comp_start && !comp_busy;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    latch     = 1'b1;
                    state_nxt = CALL;
                end
            end
            CALL: begin
                if (accept) begin
                    if (any_valid) latch = 1'b1;
                    else           state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready  = (latch && !reset) ? grant : '0;
    assign rsp_valid  = comp_done && !fifo_empty;
    assign rsp_data   = comp_returndata;
    assign rsp_id     = fifo_head;
    assign comp_stall = !rsp_ready;
    assign pop        = rsp_valid && rsp_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            pend_id             <= '0;
            comp_a              <= '0;
            comp_n              <= '0;
            err_unexpected_done <= 1'b0;
            calls_issued        <= '0;
            calls_done          <= '0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                comp_a  <= win_req.a;
                comp_n  <= win_req.n;
                pend_id <= win_id;
                rr_ptr  <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
            end
            if (accept)                  calls_issued        <= calls_issued + 1'b1;
            if (pop)                     calls_done          <= calls_done + 1'b1;
            if (comp_done && fifo_empty) err_unexpected_done <= 1'b1;
        end
    end

    sched_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_id_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .din   (pend_id),
        .pop   (pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (outstanding)
    );

endmodule

// File: tb/tb_if_loop_1_call_sched.sv
// Directed-vector bench for if_loop_1_call_sched (NREQ=4, DEPTH=4).
module tb_if_loop_1_call_sched;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [255:0] req_a;
    logic [127:0] req_n;
    logic [3:0]   req_ready;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         comp_start, comp_busy, comp_done, comp_stall;
    logic [63:0]  comp_a;
    logic [31:0]  comp_n, comp_returndata;
    logic [2:0]   outstanding;
    logic         err_unexpected_done;
    logic [31:0]  calls_issued, calls_done;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    logic [63:0] a_tab [4];
    logic [31:0] n_tab [4];

    if_loop_1_call_sched #(.NREQ(4), .DEPTH(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_a               (req_a),
        .req_n               (req_n),
        .req_ready           (req_ready),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_id              (rsp_id),
        .rsp_data            (rsp_data),
        .comp_start          (comp_start),
        .comp_busy           (comp_busy),
        .comp_a              (comp_a),
        .comp_n              (comp_n),
        .comp_done           (comp_done),
        .comp_stall          (comp_stall),
        .comp_returndata     (comp_returndata),
        .outstanding         (outstanding),
        .err_unexpected_done (err_unexpected_done),
        .calls_issued        (calls_issued),
        .calls_done          (calls_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        comp_busy = 1'b0;
        comp_done = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        a_tab[0] = 64'hDEAD_BEEF_0000_0000; n_tab[0] = 32'h11;
        a_tab[1] = 64'h0123_4567_89AB_CDEF; n_tab[1] = 32'h22;
        a_tab[2] = 64'h1000;                n_tab[2] = 32'd5;
        a_tab[3] = 64'hFFFF_0000_FFFF_0000; n_tab[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            req_a[i*64 +: 64] = a_tab[i];
            req_n[i*32 +: 32] = n_tab[i];
        end
        comp_returndata = '0;
        reset = 1'b1;
        #2;
        do_reset();

        // reset state
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_start", 64'(comp_start), 64'h0);
        chk("rst_a", comp_a, 64'h0);
        chk("rst_n", 64'(comp_n), 64'h0);
        chk("rst_out", 64'(outstanding), 64'h0);
        chk("rst_err", 64'(err_unexpected_done), 64'h0);
        chk("rst_issued", 64'(calls_issued), 64'h0);
        chk("rst_done", 64'(calls_done), 64'h0);

        // single call from requester 2
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h4);
        chk("t1_start0", 64'(comp_start), 64'h0);
        tick();
        req_valid = '0;
        #1;
        chk("t1_start", 64'(comp_start), 64'h1);
        chk("t1_a", comp_a, 64'h1000);
        chk("t1_n", 64'(comp_n), 64'd5);
        chk("t1_ready_idle", 64'(req_ready), 64'h0);
        tick();
        chk("t1_start_off", 64'(comp_start), 64'h0);
        chk("t1_out1", 64'(outstanding), 64'h1);
        chk("t1_issued", 64'(calls_issued), 64'h1);
        comp_done = 1'b1;
        comp_returndata = 32'h2A;
        #1;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_id", 64'(rsp_id), 64'h2);
        chk("t1_rsp_data", 64'(rsp_data), 64'h2A);
        chk("t1_stall", 64'(comp_stall), 64'h0);
        tick();
        comp_done = 1'b0;
        #1;
        chk("t1_out0", 64'(outstanding), 64'h0);
        chk("t1_calls_done", 64'(calls_done), 64'h1);

        // round-robin fairness with all requesters active
        do_reset();
        req_valid = 4'hF;
        #1;
        chk("rr_g0", 64'(req_ready), 64'h1);
        tick();
        chk("rr_g1", 64'(req_ready), 64'h2);
        chk("rr_start", 64'(comp_start), 64'h1);
        chk("rr_a0", comp_a, a_tab[0]);
        tick();
        chk("rr_g2", 64'(req_ready), 64'h4);
        tick();
        chk("rr_g3", 64'(req_ready), 64'h8);
        chk("rr_a2", comp_a, a_tab[2]);
        tick();
        chk("rr_g0b", 64'(req_ready), 64'h1);
        chk("rr_out3", 64'(outstanding), 64'h3);
        tick();
        chk("rr_full_start", 64'(comp_start), 64'h0);
        chk("rr_full_out", 64'(outstanding), 64'h4);
        chk("rr_full_ready", 64'(req_ready), 64'h0);
        tick();
        chk("rr_full_start2", 64'(comp_start), 64'h0);
        comp_done = 1'b1;
        comp_returndata = 32'h77;
        #1;
        chk("rr_head_id", 64'(rsp_id), 64'h0);
        tick();
        comp_done = 1'b0;
        req_valid = '0;
        #1;
        chk("rr_resume_start", 64'(comp_start), 64'h1);
        chk("rr_resume_a", comp_a, a_tab[0]);
        chk("rr_resume_out", 64'(outstanding), 64'h3);
        tick();
        chk("rr_end_out", 64'(outstanding), 64'h4);
        chk("rr_end_issued", 64'(calls_issued), 64'h5);
        chk("rr_end_done", 64'(calls_done), 64'h1);

        // component busy backpressure
        do_reset();
        comp_busy = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("bz_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bz_start", 64'(comp_start), 64'h1);
            chk("bz_a", comp_a, a_tab[1]);
            chk("bz_n", 64'(comp_n), 64'(n_tab[1]));
            chk("bz_no_ready", 64'(req_ready), 64'h0);
            chk("bz_issued0", 64'(calls_issued), 64'h0);
            tick();
        end
        req_valid = '0;
        comp_busy = 1'b0;
        #1;
        chk("bz_start_free", 64'(comp_start), 64'h1);
        tick();
        chk("bz_issued1", 64'(calls_issued), 64'h1);
        chk("bz_start_off", 64'(comp_start), 64'h0);
        chk("bz_out", 64'(outstanding), 64'h1);

        // response backpressure
        comp_done = 1'b1;
        comp_returndata = 32'h55;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_stall", 64'(comp_stall), 64'h1);
            chk("bp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_id", 64'(rsp_id), 64'h1);
            chk("bp_out", 64'(outstanding), 64'h1);
            chk("bp_done0", 64'(calls_done), 64'h0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_stall_off", 64'(comp_stall), 64'h0);
        tick();
        comp_done = 1'b0;
        #1;
        chk("bp_done1", 64'(calls_done), 64'h1);
        chk("bp_out0", 64'(outstanding), 64'h0);

        // in-order id routing: 3, 1, 0
        do_reset();
        req_valid = 4'b1000;
        #1;
        chk("io_g3", 64'(req_ready), 64'h8);
        tick();
        req_valid = 4'b0010;
        #1;
        chk("io_g1", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("io_g0", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        tick();
        chk("io_out3", 64'(outstanding), 64'h3);
        comp_done = 1'b1;
        comp_returndata = 32'd7;
        #1;
        chk("io_id_a", 64'(rsp_id), 64'h3);
        chk("io_data_a", 64'(rsp_data), 64'd7);
        tick();
        comp_returndata = 32'd8;
        #1;
        chk("io_id_b", 64'(rsp_id), 64'h1);
        chk("io_data_b", 64'(rsp_data), 64'd8);
        tick();
        comp_returndata = 32'd9;
        #1;
        chk("io_id_c", 64'(rsp_id), 64'h0);
        chk("io_data_c", 64'(rsp_data), 64'd9);
        tick();
        comp_done = 1'b0;
        #1;
        chk("io_out0", 64'(outstanding), 64'h0);
        chk("io_done3", 64'(calls_done), 64'h3);
        chk("io_issued3", 64'(calls_issued), 64'h3);
        chk("io_err0", 64'(err_unexpected_done), 64'h0);

        // unexpected done, sticky error, then async reset mid-flight
        comp_done = 1'b1;
        #1;
        chk("er_valid", 64'(rsp_valid), 64'h0);
        chk("er_stall", 64'(comp_stall), 64'h0);
        tick();
        comp_done = 1'b0;
        #1;
        chk("er_set", 64'(err_unexpected_done), 64'h1);
        tick();
        chk("er_hold", 64'(err_unexpected_done), 64'h1);
        req_valid = 4'b0011;
        #1;
        chk("er_g1", 64'(req_ready), 64'h2);
        tick();
        chk("er_g0", 64'(req_ready), 64'h1);
        tick();
        tick();
        chk("er_out2", 64'(outstanding), 64'h2);
        chk("er_start_pre", 64'(comp_start), 64'h1);
        chk("er_issued", 64'(calls_issued), 64'h5);
        #2;
        reset = 1'b1;
        req_valid = '0;
        #1;
        chk("ar_out", 64'(outstanding), 64'h0);
        chk("ar_issued", 64'(calls_issued), 64'h0);
        chk("ar_done", 64'(calls_done), 64'h0);
        chk("ar_err", 64'(err_unexpected_done), 64'h0);
        chk("ar_start", 64'(comp_start), 64'h0);
        chk("ar_a", comp_a, 64'h0);
        tick();
        reset = 1'b0;
        comp_done = 1'b1;
        #1;
        chk("ar_no_rsp", 64'(rsp_valid), 64'h0);
        comp_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
